// File: rtl/scoreboard_hazard_unit.sv
// Per-register latency scoreboard for the in-order pipeline: RAW/WAW stall
// detection, forwarding hints, memory-port reservation and a stall counter.
module scoreboard_hazard_unit #(
    parameter int NUM_REGS  = 32,
    parameter int REG_W     = 5,
    parameter int NUM_SRC   = 2,
    parameter int LAT_W     = 3,
    parameter int MEM_DELAY = 2,
    parameter int PERF_W    = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic                     id_flush,
    input  logic [NUM_SRC*REG_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]       id_rs_used,
    input  logic                     id_wr_rd,
    input  logic [REG_W-1:0]         id_rd,
    input  logic [LAT_W-1:0]         id_lat,
    input  logic                     id_is_mem,
    output logic                     if_id_enable,
    output logic                     id_ex_enable,
    output logic                     has_data_hazard,
    output logic                     mem_port_busy,
    output logic [NUM_SRC-1:0]       src_fwd,
    output logic [PERF_W-1:0]        stall_cycles
);

    // cnt[0] is cleared by reset and never written afterwards, so x0 reads as 0.
    logic [LAT_W-1:0]     cnt [NUM_REGS];
    logic [MEM_DELAY-1:0] mem_pipe;
    logic [LAT_W-1:0]     eff_lat;
    logic                 raw_any;
    logic                 waw;
    logic                 issue;

    assign eff_lat = (id_lat == '0) ? LAT_W'(1) : id_lat;

    always_comb begin
        raw_any = 1'b0;
        src_fwd = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && (id_rs[i*REG_W +: REG_W] != '0)) begin
                if (cnt[id_rs[i*REG_W +: REG_W]] > LAT_W'(1))
                    raw_any = 1'b1;
                if (cnt[id_rs[i*REG_W +: REG_W]] == LAT_W'(1))
                    src_fwd[i] = 1'b1;
            end
        end
    end

    assign waw             = id_wr_rd && (id_rd != '0) && (cnt[id_rd] > eff_lat);
    assign has_data_hazard = id_valid && !id_flush && (raw_any || waw);
    assign if_id_enable    = !has_data_hazard;
    assign id_ex_enable    = !has_data_hazard;
    assign issue           = id_valid && !id_flush && !has_data_hazard;
    assign mem_port_busy   = mem_pipe[MEM_DELAY-1];

    // Issue write takes precedence over the per-cycle decrement of the same entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
        end else begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (issue && id_wr_rd && (id_rd == REG_W'(r)))
                    cnt[r] <= eff_lat;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - LAT_W'(1);
            end
        end
    end

    generate
        if (MEM_DELAY == 1) begin : g_mem_single
            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    mem_pipe <= '0;
                else
                    mem_pipe <= issue && id_is_mem;
            end
        end else begin : g_mem_shift
            always_ff @(posedge clock or posedge reset) begin
                if (reset)
                    mem_pipe <= '0;
                else
                    mem_pipe <= {mem_pipe[MEM_DELAY-2:0], issue && id_is_mem};
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (has_data_hazard && (stall_cycles != '1))
            stall_cycles <= stall_cycles + PERF_W'(1);
    end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed plus random stimulus against a cycle-timestamp model of the
// scoreboard: each register remembers the cycle its result becomes ready.
module tb_scoreboard_hazard_unit;

    logic        clock;
    logic        reset;
    logic        id_valid;
    logic        id_flush;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic        id_wr_rd;
    logic [4:0]  id_rd;
    logic [2:0]  id_lat;
    logic        id_is_mem;
    logic        if_id_enable;
    logic        id_ex_enable;
    logic        has_data_hazard;
    logic        mem_port_busy;
    logic [1:0]  src_fwd;
    logic [15:0] stall_cycles;

    scoreboard_hazard_unit #(
        .NUM_REGS(32), .REG_W(5), .NUM_SRC(2), .LAT_W(3), .MEM_DELAY(2), .PERF_W(16)
    ) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_wr_rd(id_wr_rd), .id_rd(id_rd),
        .id_lat(id_lat), .id_is_mem(id_is_mem), .if_id_enable(if_id_enable),
        .id_ex_enable(id_ex_enable), .has_data_hazard(has_data_hazard),
        .mem_port_busy(mem_port_busy), .src_fwd(src_fwd), .stall_cycles(stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model state: absolute cycle at which each register's result is ready
    // (remaining latency = ready - now), issue cycles of memory ops, stall count.
    int  cyc;
    int  ready_at [32];
    bit  mem_issued [int];
    int  m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int remaining(input int r);
        if (r == 0) return 0;
        return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        mem_issued.delete();
        m_stall = 0;
    endtask

    bit m_haz;
    bit [1:0] m_fwd;

    task automatic check_outputs(input bit v, f, input int rs1, rs2, input bit [1:0] used,
                                 input bit wr, input int rd, input int lat);
        int eff;
        int rs [2];
        bit raw;
        bit waw;
        eff = (lat == 0) ? 1 : lat;
        rs[0] = rs1;
        rs[1] = rs2;
        raw = 0;
        m_fwd = 0;
        for (int i = 0; i < 2; i++) begin
            if (used[i] && rs[i] != 0) begin
                if (remaining(rs[i]) > 1) raw = 1;
                if (remaining(rs[i]) == 1) m_fwd[i] = 1;
            end
        end
        waw = wr && rd != 0 && remaining(rd) > eff;
        m_haz = v && !f && (raw || waw);
        chk("has_data_hazard", has_data_hazard, m_haz);
        chk("if_id_enable", if_id_enable, !m_haz);
        chk("id_ex_enable", id_ex_enable, !m_haz);
        chk("src_fwd", src_fwd, m_fwd);
        chk("mem_port_busy", mem_port_busy, mem_issued.exists(cyc - 2));
        chk("stall_cycles", stall_cycles, m_stall);
    endtask

    // One pipeline cycle: drive at negedge, check at +1, advance model at posedge.
    task automatic step(input bit v, f, input int rs1, rs2, input bit [1:0] used,
                        input bit wr, input int rd, input int lat, input bit mem);
        bit issue;
        int eff;
        id_valid = v; id_flush = f;
        id_rs = {5'(rs2), 5'(rs1)}; id_rs_used = used;
        id_wr_rd = wr; id_rd = 5'(rd); id_lat = 3'(lat); id_is_mem = mem;
        #1;
        check_outputs(v, f, rs1, rs2, used, wr, rd, lat);
        issue = v && !f && !m_haz;
        eff = (lat == 0) ? 1 : lat;
        @(posedge clock);
        if (issue && wr && rd != 0) ready_at[rd] = cyc + 1 + eff;
        if (issue && mem) mem_issued[cyc] = 1;
        if (m_haz && m_stall != 65535) m_stall++;
        cyc++;
        @(negedge clock);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 0; id_flush = 0; id_rs = '0; id_rs_used = '0;
        id_wr_rd = 0; id_rd = '0; id_lat = '0; id_is_mem = 0;
        cyc = 0;
        model_clear();
        @(negedge clock);
        #1;
        chk("reset if_id_enable", if_id_enable, 1);
        chk("reset hazard", has_data_hazard, 0);
        chk("reset busy", mem_port_busy, 0);
        chk("reset stall_cycles", stall_cycles, 0);
        @(negedge clock);
        reset = 1'b0;

        // ALU producer then consumer: forward, no stall
        step(1, 0, 0, 0, 2'b00, 1, 5, 1, 0);
        step(1, 0, 5, 0, 2'b01, 1, 11, 1, 0);
        chk("alu fwd value", m_fwd, 2'b01);
        // Load producer then consumer on rs2: one stall then forward
        step(1, 0, 0, 0, 2'b00, 1, 6, 2, 1);
        step(1, 0, 1, 6, 2'b11, 1, 12, 1, 0);
        step(1, 0, 1, 6, 2'b11, 1, 12, 1, 0);
        // MUL then shorter write to same rd: WAW for two cycles
        step(1, 0, 0, 0, 2'b00, 1, 7, 3, 0);
        step(1, 0, 0, 0, 2'b00, 1, 7, 1, 0);
        step(1, 0, 0, 0, 2'b00, 1, 7, 1, 0);
        step(1, 0, 0, 0, 2'b00, 1, 7, 1, 0);
        step(1, 0, 7, 0, 2'b01, 0, 0, 1, 0);
        // Memory op: port busy two cycles after issue; flushed copy leaves no trace
        step(1, 0, 0, 0, 2'b00, 1, 8, 2, 1);
        idle(); idle(); idle();
        step(1, 1, 0, 0, 2'b00, 1, 8, 2, 1);
        step(1, 0, 8, 0, 2'b01, 0, 0, 1, 0);
        idle(); idle();
        // x0 never tracked
        step(1, 0, 0, 0, 2'b00, 1, 0, 2, 1);
        step(1, 0, 0, 0, 2'b11, 0, 0, 1, 0);
        // Pending load with a flushed reader: no hazard
        step(1, 0, 0, 0, 2'b00, 1, 9, 2, 1);
        step(1, 1, 9, 9, 2'b11, 0, 0, 1, 0);
        idle();

        // Pending MUL, stalled reader, then asynchronous reset mid-cycle
        step(1, 0, 0, 0, 2'b00, 1, 10, 3, 0);
        id_valid = 1; id_flush = 0; id_rs = {5'd0, 5'd10}; id_rs_used = 2'b01;
        id_wr_rd = 0; id_rd = '0; id_lat = 3'd1; id_is_mem = 0;
        #1;
        check_outputs(1, 0, 10, 0, 2'b01, 0, 0, 1);
        reset = 1'b1;
        #1;
        model_clear();
        chk("async rst hazard", has_data_hazard, 0);
        chk("async rst enable", id_ex_enable, 1);
        chk("async rst fwd", src_fwd, 0);
        chk("async rst busy", mem_port_busy, 0);
        chk("async rst stall_cycles", stall_cycles, 0);
        #1;
        reset = 1'b0;
        @(posedge clock);
        cyc++;
        @(negedge clock);
        step(1, 0, 10, 10, 2'b11, 1, 10, 1, 0);

        // Random traffic over a small register window to force frequent hazards
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(9, 0) < 8,
                 $urandom_range(9, 0) == 0,
                 int'($urandom_range(7, 0)),
                 int'($urandom_range(7, 0)),
                 2'($urandom_range(3, 0)),
                 $urandom_range(3, 0) != 0,
                 int'($urandom_range(7, 0)),
                 int'($urandom_range(7, 0)),
                 $urandom_range(2, 0) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
- Parametrised, stateful hazard unit for the in-order RISC-V pipeline.
- Replaces fixed load-use detection with a per-register latency scoreboard, so multi-cycle producers (load, MUL, future DIV) stall exactly as long as needed.
- Also tracks when a single shared memory port is reserved for the MEM stage, so fetch can yield.
- Sits beside the decode stage: sees the IF/ID instruction, drives the IF/ID and ID/EX enables, and reports per-source forwarding.

Parameters:
- NUM_REGS, 32, architectural registers; index 0 is hardwired zero and never tracked.
- REG_W, 5, register index width, equal to $clog2(NUM_REGS).
- NUM_SRC, 2, source operands checked per instruction (3 reserved for FMA-style ops).
- LAT_W, 3, width of latency fields; maximum producer latency is 2**LAT_W-1.
- MEM_DELAY, 2, cycles from issue until the memory op occupies the port (EX then MEM); must be ≥1.
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; clears all state
- id_valid  in  1  IF/ID holds a real instruction
- id_flush  in  1  branch redirect; the IF/ID instruction is squashed this cycle
- id_rs  in  NUM_SRC*REG_W  source indices; source i is at [i*REG_W +: REG_W]
- id_rs_used  in  NUM_SRC  source i is actually read
- id_wr_rd  in  1  instruction writes rd
- id_rd  in  REG_W  destination index
- id_lat  in  LAT_W  cycles until the result is forwardable (ALU=1, load=2, MUL=3); 0 is treated as 1
- id_is_mem  in  1  instruction is a load or store
- if_id_enable  out  1  IF/ID register may advance
- id_ex_enable  out  1  ID/EX loads the decoded instruction; when 0, ID/EX loads a bubble
- has_data_hazard  out  1  RAW or WAW stall this cycle
- mem_port_busy  out  1  memory port owned by MEM this cycle; fetch must not access
- src_fwd  out  NUM_SRC  source i gets its value from an in-flight producer via forwarding
- stall_cycles  out  PERF_W  saturating count of cycles with has_data_hazard=1

Behaviour:
- State:
  - cnt[r], LAT_W bits, for r=1..NUM_REGS-1; cnt[0] is a constant 0.
  - mem_pipe, MEM_DELAY-bit shift register.
  - stall_cycles counter.
- Reset (async, active-high): all cnt=0, mem_pipe=0, stall_cycles=0.
- Outputs after reset: if_id_enable=1, id_ex_enable=1, has_data_hazard=0, mem_port_busy=0, src_fwd=0.
- eff_lat = (id_lat==0) ? 1 : id_lat.
- RAW for source i: id_rs_used[i] && rs_i!=0 && cnt[rs_i]>1.
- WAW: id_wr_rd && id_rd!=0 && cnt[id_rd]>eff_lat. This prevents a younger, shorter op from retiring before an older one.
- has_data_hazard = id_valid && !id_flush && (any RAW || WAW). This output is combinational, same cycle.
- if_id_enable = id_ex_enable = !has_data_hazard.
- src_fwd[i] = id_rs_used[i] && rs_i!=0 && cnt[rs_i]==1. This output is combinational.
- Issue = id_valid && !id_flush && !has_data_hazard.
- Per clock edge, every cnt[r]!=0 decrements by 1. Then, on issue with id_wr_rd && id_rd!=0, cnt[id_rd] <= eff_lat. The issue write overrides the decrement for the same register.
- No issue means no scoreboard write. Stalled and flushed instructions leave no trace.
- mem_pipe <= {mem_pipe[MEM_DELAY-2:0], issue && id_is_mem}; for MEM_DELAY=1 it is just the new bit.
- mem_port_busy = mem_pipe[MEM_DELAY-1].
- mem_pipe is independent of data stalls: once issued, an op always reaches MEM.
- stall_cycles increments when has_data_hazard=1 and holds at 2**PERF_W-1.
- Flush has priority over stall: when id_flush=1, has_data_hazard=0, enables=1, and nothing issues.
- Writes to x0, and reads of x0, never stall and never forward.
- Back-to-back dependents:
  - ALU→use: 0 stall cycles, src_fwd=1.
  - load→use: 1 stall cycle.
  - lat-L→use: L-1 stall cycles.
- Reset mid-stall clears every pending count. The next cycle must not stall.

Test Plan:
- Reset then `add x5` (lat 1), next `sub` rs1=x5 → no stall; src_fwd[0]=1; cnt[5] goes 1→0.
- `lw x6` (lat 2), next `add` rs2=x6 → has_data_hazard=1 for exactly 1 cycle, enables=0, stall_cycles=1; then issue with src_fwd[1]=1.
- `mul x7` (lat 3) then `addi x7` (lat 1) → WAW stall for 2 cycles; cnt[7] ends at 1.
- `lw x8` issued at cycle t → mem_port_busy=1 only at t+2 (MEM_DELAY=2). The same op with id_flush=1 → never busy and cnt[8] stays 0.
- `lw x0`, then reader of x0 → no stall, src_fwd=0. Pending `lw x9` followed by a reader with id_flush=1 → no hazard, enables=1.
- Pending `mul x10` (cnt=3) with reset asserted asynchronously mid-cycle → all outputs return to reset values immediately; a following reader of x10 does not stall.
